vdot_seq: RTL and testbench

Multi-cycle sequencer for the custom VDOT instruction (opcode 7'b0101011). On a start pulse from decode it fetches `VLEN` word pairs from data memory at `rs1`/`rs2` base addresses, multiply-accumulates them, and returns one 32-bit result for register write-back to `rd`. It shares the data-memory read port with the core, with core loads/stores taking priority. It holds the pipeline stalled until write-back completes.

---
 rtl/vdot_seq.sv | 208 ++++++++++++++++++++
 tb/tb_vdot_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdot_seq.sv
// vdot_seq - multi-cycle sequencer for the VDOT instruction (opcode 7'b0101011).
//
// Fetches VLEN word pairs A[i], B[i] from data memory at base_a + 4*i and
// base_b + 4*i, multiply-accumulates them into a 64-bit accumulator, and
// returns one 32-bit result for write-back to rd. The memory read port is
// shared with the core; core loads/stores win whenever core_mem_busy_i is high.
// The front end is frozen through stall_o until the write-back cycle.
//
// Build option:
//   VDOT_SAT_EN  defined     : wb_data_o is the accumulator clamped to int32.
//                not defined : wb_data_o is acc[31:0] (two's-complement wrap).
//
// Parameters:
//   VLEN             elements per dot product, 1..255.
//
// Ports:
//   clk_i            core clock, all state on the rising edge.
//   rst_i            synchronous active-high reset.
//   start_i          VDOT decoded in ID; sampled only while idle.
//   base_a_i/_b_i    rs1/rs2 values: byte addresses of element 0 of A/B.
//   rd_in_i          destination register index.
//   core_mem_busy_i  core owns the memory port this cycle.
//   mem_req_o        read request (combinational).
//   mem_addr_o       read address (combinational, stable while waiting).
//   mem_gnt_i        request accepted this cycle.
//   mem_rvalid_i     read data valid, one cycle after the granting cycle.
//   mem_rdata_i      read data.
//   busy_o           sequencer not idle.
//   stall_o          start_i | busy_o, freezes IF/ID.
//   wb_en_o          one-cycle register write strobe.
//   wb_rd_o          destination register for the write-back.
//   wb_data_o        dot-product result.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start_i
// S_RD_A   | requesting A[idx]; held until the request is granted
// S_WAIT_A | waiting for A[idx] read data
// S_RD_B   | requesting B[idx]; held until the request is granted
// S_WAIT_B | waiting for B[idx]; accumulate, then next element or done
// S_DONE   | write-back strobe cycle

module vdot_seq #(
  parameter int unsigned VLEN = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_a_i,
  input  logic [31:0] base_b_i,
  input  logic [4:0]  rd_in_i,
  input  logic        core_mem_busy_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o
);

  localparam logic [7:0] LAST_IDX = 8'(VLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_WAIT_A,
    S_RD_B,
    S_WAIT_B,
    S_DONE
  } state_e;

  state_e      state_q;
  logic [31:0] base_a_q;
  logic [31:0] base_b_q;
  logic [4:0]  rd_q;
  logic [7:0]  idx_q;
  logic [31:0] op_a_q;
  logic [63:0] acc_q;
  logic        busy_q;
  logic        wb_en_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;

  logic [31:0] elem_off;
  logic [63:0] op_a_ext;
  logic [63:0] op_b_ext;
  logic [63:0] prod;
  logic [63:0] acc_d;
  logic [31:0] result_d;
  logic        rd_phase;
  logic        grant;

  assign rd_phase = (state_q == S_RD_A) || (state_q == S_RD_B);
  assign elem_off = {22'd0, idx_q, 2'b00};
  assign grant    = mem_req_o & mem_gnt_i;

  // The core has priority: the request simply drops while it owns the port,
  // and the FSM holds in the read state with the address unchanged.
  assign mem_req_o = rd_phase & ~core_mem_busy_i;

  always_comb begin
    mem_addr_o = 32'd0;
    case (state_q)
      S_RD_A:  mem_addr_o = base_a_q + elem_off;
      S_RD_B:  mem_addr_o = base_b_q + elem_off;
      default: mem_addr_o = 32'd0;
    endcase
  end

  // Sign-extend both operands to 64 bits; the low 64 bits of the unsigned
  // product of the extended values equal the signed 32x32 product.
  assign op_a_ext = {{32{op_a_q[31]}}, op_a_q};
  assign op_b_ext = {{32{mem_rdata_i[31]}}, mem_rdata_i};
  assign prod     = op_a_ext * op_b_ext;
  assign acc_d    = acc_q + prod;

  always_comb begin
`ifdef VDOT_SAT_EN
    // In int32 range exactly when bits 63..31 are all copies of the sign.
    if (acc_d[63:31] == {33{acc_d[63]}}) begin
      result_d = acc_d[31:0];
    end else if (acc_d[63]) begin
      result_d = 32'h8000_0000;
    end else begin
      result_d = 32'h7FFF_FFFF;
    end
`else
    result_d = acc_d[31:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      base_a_q  <= 32'd0;
      base_b_q  <= 32'd0;
      rd_q      <= 5'd0;
      idx_q     <= 8'd0;
      op_a_q    <= 32'd0;
      acc_q     <= 64'd0;
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      wb_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            base_a_q <= base_a_i;
            base_b_q <= base_b_i;
            rd_q     <= rd_in_i;
            idx_q    <= 8'd0;
            acc_q    <= 64'd0;
            busy_q   <= 1'b1;
            state_q  <= S_RD_A;
          end
        end
        S_RD_A: begin
          if (grant) state_q <= S_WAIT_A;
        end
        S_WAIT_A: begin
          if (mem_rvalid_i) begin
            op_a_q  <= mem_rdata_i;
            state_q <= S_RD_B;
          end
        end
        S_RD_B: begin
          if (grant) state_q <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (mem_rvalid_i) begin
            acc_q <= acc_d;
            if (idx_q == LAST_IDX) begin
              // Result registered here so it is on wb_data_o during DONE.
              wb_en_q   <= 1'b1;
              wb_rd_q   <= rd_q;
              wb_data_q <= result_d;
              state_q   <= S_DONE;
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= S_RD_A;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign stall_o   = start_i | busy_q;
  assign wb_en_o   = wb_en_q;
  assign wb_rd_o   = wb_rd_q;
  assign wb_data_o = wb_data_q;

endmodule

// File: tb/tb_vdot_seq.sv
`timescale 1ns/1ps
module tb_vdot_seq;
  localparam int VLEN = 4;
  localparam int LOGN = 128;

  logic        clk = 1'b0;
  logic        rst, start, core_mem_busy, mem_gnt, spur;
  logic [31:0] base_a, base_b, mem_addr;
  logic [4:0]  rd_in, wb_rd;
  logic        mem_req, busy, stall, wb_en;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rel;
  int stray_wb = 0;
  logic op_active = 1'b0;
  int restart_rel = -1;
  int rst_rel = -1;
  int spur_rel = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vdot_seq #(.VLEN(VLEN)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .base_a_i(base_a), .base_b_i(base_b), .rd_in_i(rd_in),
    .core_mem_busy_i(core_mem_busy),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .busy_o(busy), .stall_o(stall),
    .wb_en_o(wb_en), .wb_rd_o(wb_rd), .wb_data_o(wb_data)
  );

  // ---------------- memory / arbiter model ----------------
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hBAD0_0000 ^ a;
  endfunction

  assign mem_gnt = mem_req;
  always @(posedge clk) begin
    mem_rvalid <= (mem_req & mem_gnt) | spur;
    mem_rdata  <= (mem_req & mem_gnt) ? mem_rd(mem_addr) : 32'h5A5A_5A5A;
  end

  logic contend [LOGN];
  always_comb rel = cyc - start_cyc;
  always_comb begin
    core_mem_busy = 1'b0;
    if (op_active && rel >= 0 && rel < LOGN) core_mem_busy = contend[rel];
  end

  // ---------------- monitor ----------------
  typedef struct { int rel; logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { int rel; logic [31:0] addr; } gr_t;
  wb_t wbq[$];
  gr_t grq[$];
  logic        req_log  [LOGN];
  logic [31:0] addr_log [LOGN];
  logic        busy_log [LOGN];
  logic        stall_log[LOGN];

  always @(negedge clk) begin
    if (op_active && rel >= 0 && rel < LOGN) begin
      req_log[rel]   = mem_req;
      addr_log[rel]  = mem_addr;
      busy_log[rel]  = busy;
      stall_log[rel] = stall;
      if (wb_en) wbq.push_back('{rel, wb_rd, wb_data});
      if (mem_req && mem_gnt) grq.push_back('{rel, mem_addr});
    end else if (wb_en) begin
      stray_wb++;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] va [VLEN];
  logic [31:0] vb [VLEN];
  int exp_g[$];

  function automatic logic [31:0] exp_result();
    longint acc = 0;
    for (int i = 0; i < VLEN; i++)
      acc += longint'($signed(va[i])) * longint'($signed(vb[i]));
`ifdef VDOT_SAT_EN
    if (acc > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (acc < -64'sh8000_0000) return 32'h8000_0000;
`endif
    return acc[31:0];
  endfunction

  // Reads are strictly sequential: each waits out core-busy cycles, is granted,
  // and the next read may start two cycles after the grant. Returns DONE cycle.
  function automatic int model_timeline();
    int t = 1;
    exp_g.delete();
    for (int k = 0; k < 2 * VLEN; k++) begin
      while (t < LOGN && contend[t]) t++;
      exp_g.push_back(t);
      t += 2;
    end
    return exp_g[2 * VLEN - 1] + 2;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] ba, input logic [31:0] bb, input int k);
    return ((k % 2) == 0 ? ba : bb) + 32'(4 * (k / 2));
  endfunction

  task automatic clear_contend();
    for (int i = 0; i < LOGN; i++) contend[i] = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] ba, input logic [31:0] bb, input logic [4:0] rd, input int ncyc);
    for (int i = 0; i < VLEN; i++) begin
      mem[ba + 32'(4 * i)] = va[i];
      mem[bb + 32'(4 * i)] = vb[i];
    end
    wbq.delete();
    grq.delete();
    @(posedge clk); #1;
    start_cyc = cyc;
    op_active = 1'b1;
    base_a = ba; base_b = bb; rd_in = rd; start = 1'b1;
    for (int r = 1; r <= ncyc; r++) begin
      @(posedge clk); #1;
      start = (r == restart_rel);
      rst   = (r == rst_rel);
      spur  = (r == spur_rel);
      base_a = $urandom; base_b = $urandom; rd_in = 5'($urandom);
    end
    op_active = 1'b0; start = 1'b0; rst = 1'b0; spur = 1'b0;
    restart_rel = -1; rst_rel = -1; spur_rel = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'd0) begin n_err++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL reset_stall_start got %b exp 1", stall); end
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en got %b exp 0", wb_en); end
    n_cmp++; if (wb_rd !== 5'd0) begin n_err++; $display("FAIL reset_wb_rd got %h exp 0", wb_rd); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall_idle got %b exp 0", stall); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int done;
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    clear_contend();
    done = model_timeline();
    run_op(32'h100, 32'h200, 5'd5, done + 5);
    n_cmp++; if (wbq.size() !== 1) begin n_err++; $display("FAIL basic_wb_count got %0d exp 1", wbq.size()); end
    if (wbq.size() > 0) begin
      n_cmp++; if (wbq[0].rel !== 17) begin n_err++; $display("FAIL basic_wb_cycle got %0d exp 17", wbq[0].rel); end
      n_cmp++; if (wbq[0].rd !== 5'd5) begin n_err++; $display("FAIL basic_wb_rd got %0d exp 5", wbq[0].rd); end
      n_cmp++; if (wbq[0].data !== 32'd70) begin n_err++; $display("FAIL basic_wb_data got %0d exp 70", wbq[0].data); end
    end
    n_cmp++; if (grq.size() !== 2 * VLEN) begin n_err++; $display("FAIL basic_grant_count got %0d exp %0d", grq.size(), 2 * VLEN); end
    for (int k = 0; k < grq.size() && k < 2 * VLEN; k++) begin
      n_cmp++;
      if (grq[k].addr !== exp_addr(32'h100, 32'h200, k) || grq[k].rel !== exp_g[k]) begin
        n_err++;
        $display("FAIL basic_grant%0d got addr %h @%0d exp addr %h @%0d", k, grq[k].addr, grq[k].rel, exp_addr(32'h100, 32'h200, k), exp_g[k]);
      end
    end
    for (int r = 0; r <= done + 2; r++) begin
      n_cmp++;
      if (busy_log[r] !== (r >= 1 && r <= done) || stall_log[r] !== (r <= done)) begin
        n_err++;
        $display("FAIL basic_busy_stall@%0d got busy %b stall %b exp busy %b stall %b", r, busy_log[r], stall_log[r], (r >= 1 && r <= done), (r <= done));
      end
    end
  endtask

  task automatic test_signed();
    va = '{32'(-3), 32'd2, 32'd0, 32'd7};
    vb = '{32'd4, 32'(-5), 32'd9, 32'(-1)};
    clear_contend();
    run_op(32'h300, 32'h400, 5'd9, 22);
    n_cmp++; if (wbq.size() !== 1) begin n_err++; $display("FAIL signed_wb_count got %0d exp 1", wbq.size()); end
    if (wbq.size() > 0) begin
      n_cmp++; if (wbq[0].data !== 32'hFFFF_FFE3) begin n_err++; $display("FAIL signed_wb_data got %h exp ffffffe3", wbq[0].data); end
      n_cmp++; if (wbq[0].rd !== 5'd9) begin n_err++; $display("FAIL signed_wb_rd got %0d exp 9", wbq[0].rd); end
    end
  endtask

  task automatic test_contention();
    int done;
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    clear_contend();
    contend[7] = 1'b1; contend[8] = 1'b1; contend[9] = 1'b1;
    done = model_timeline();
    run_op(32'h100, 32'h200, 5'd5, done + 5);
    n_cmp++; if (wbq.size() !== 1) begin n_err++; $display("FAIL contend_wb_count got %0d exp 1", wbq.size()); end
    if (wbq.size() > 0) begin
      n_cmp++; if (wbq[0].rel !== 20) begin n_err++; $display("FAIL contend_wb_cycle got %0d exp 20", wbq[0].rel); end
      n_cmp++; if (wbq[0].data !== 32'd70) begin n_err++; $display("FAIL contend_wb_data got %0d exp 70", wbq[0].data); end
    end
    for (int r = 7; r <= 10; r++) begin
      n_cmp++;
      if (req_log[r] !== (r == 10) || addr_log[r] !== 32'h204) begin
        n_err++;
        $display("FAIL contend_port@%0d got req %b addr %h exp req %b addr 00000204", r, req_log[r], addr_log[r], (r == 10));
      end
    end
  endtask

  task automatic test_reset_mid();
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    clear_contend();
    rst_rel = 6;
    spur_rel = 7;
    run_op(32'h100, 32'h200, 5'd5, 22);
    n_cmp++; if (wbq.size() !== 0) begin n_err++; $display("FAIL rstmid_wb_count got %0d exp 0", wbq.size()); end
    n_cmp++; if (busy_log[7] !== 1'b0 || busy_log[8] !== 1'b0 || busy_log[12] !== 1'b0) begin
      n_err++; $display("FAIL rstmid_busy got %b%b%b exp 000", busy_log[7], busy_log[8], busy_log[12]);
    end
    va = '{32'(-3), 32'd2, 32'd0, 32'd7};
    vb = '{32'd4, 32'(-5), 32'd9, 32'(-1)};
    run_op(32'h500, 32'h600, 5'd17, 22);
    n_cmp++; if (wbq.size() !== 1) begin n_err++; $display("FAIL rstmid_op2_count got %0d exp 1", wbq.size()); end
    if (wbq.size() > 0) begin
      n_cmp++; if (wbq[0].rel !== 4 * VLEN + 1) begin n_err++; $display("FAIL rstmid_op2_cycle got %0d exp %0d", wbq[0].rel, 4 * VLEN + 1); end
      n_cmp++; if (wbq[0].data !== 32'hFFFF_FFE3 || wbq[0].rd !== 5'd17) begin
        n_err++; $display("FAIL rstmid_op2_result got %h rd %0d exp ffffffe3 rd 17", wbq[0].data, wbq[0].rd);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] e_sat, e_wrap, e;
    clear_contend();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin va = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
                 vb = '{32'd4, 32'd4, 32'd4, 32'd4}; e_sat = 32'h7FFF_FFFF; e_wrap = 32'h0; end
        1: begin va = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
                 vb = '{32'd1, 32'd1, 32'd1, 32'd1}; e_sat = 32'h8000_0000; e_wrap = 32'h0; end
        2: begin va = '{32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0};
                 vb = '{32'd1, 32'd1, 32'd1, 32'd1}; e_sat = 32'h7FFF_FFFF; e_wrap = 32'h7FFF_FFFF; end
        3: begin va = '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0};
                 vb = '{32'd1, 32'd1, 32'd1, 32'd1}; e_sat = 32'h7FFF_FFFF; e_wrap = 32'h8000_0000; end
        default: begin va = '{32'h8000_0000, 32'd0, 32'd0, 32'd0};
                 vb = '{32'd1, 32'd1, 32'd1, 32'd1}; e_sat = 32'h8000_0000; e_wrap = 32'h8000_0000; end
      endcase
`ifdef VDOT_SAT_EN
      e = e_sat;
`else
      e = e_wrap;
`endif
      run_op(32'h1000, 32'h2000, 5'(c + 1), 22);
      n_cmp++;
      if (wbq.size() !== 1 || wbq[0].data !== e) begin
        n_err++;
        $display("FAIL sat_case%0d got count %0d data %h exp count 1 data %h", c, wbq.size(), (wbq.size() > 0) ? wbq[0].data : 32'hx, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    clear_contend();
    restart_rel = 5;
    run_op(32'h100, 32'h200, 5'd5, 40);
    n_cmp++; if (wbq.size() !== 1) begin n_err++; $display("FAIL b2b_wb_count got %0d exp 1", wbq.size()); end
    n_cmp++; if (grq.size() !== 2 * VLEN) begin n_err++; $display("FAIL b2b_grant_count got %0d exp %0d", grq.size(), 2 * VLEN); end
    if (wbq.size() > 0) begin
      n_cmp++; if (wbq[0].rel !== 17 || wbq[0].data !== 32'd70) begin
        n_err++; $display("FAIL b2b_wb got @%0d %0d exp @17 70", wbq[0].rel, wbq[0].data);
      end
    end
  endtask

  task automatic test_random();
    int done;
    logic [31:0] ba, bb, e;
    logic [4:0] rd;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < VLEN; i++) begin
        if (it % 2 == 0) begin
          va[i] = $urandom; vb[i] = $urandom;
        end else begin
          va[i] = 32'($signed(10'($urandom))); vb[i] = 32'($signed(10'($urandom)));
        end
      end
      ba = (it == 3) ? 32'hFFFF_FFF8 : $urandom;
      bb = ba + 32'h0001_0000 + 32'($urandom_range(0, 255) * 4);
      rd = 5'($urandom);
      clear_contend();
      for (int t = 1; t < 60; t++) contend[t] = ($urandom_range(0, 3) == 0);
      done = model_timeline();
      e = exp_result();
      run_op(ba, bb, rd, done + 5);
      n_cmp++;
      if (wbq.size() !== 1) begin
        n_err++; $display("FAIL rand%0d_wb_count got %0d exp 1", it, wbq.size());
      end else begin
        n_cmp++;
        if (wbq[0].rel !== done || wbq[0].rd !== rd || wbq[0].data !== e) begin
          n_err++;
          $display("FAIL rand%0d_wb got @%0d rd %0d data %h exp @%0d rd %0d data %h", it, wbq[0].rel, wbq[0].rd, wbq[0].data, done, rd, e);
        end
      end
      n_cmp++;
      if (grq.size() !== 2 * VLEN) begin
        n_err++; $display("FAIL rand%0d_grant_count got %0d exp %0d", it, grq.size(), 2 * VLEN);
      end else begin
        for (int k = 0; k < 2 * VLEN; k++) begin
          n_cmp++;
          if (grq[k].addr !== exp_addr(ba, bb, k) || grq[k].rel !== exp_g[k]) begin
            n_err++;
            $display("FAIL rand%0d_grant%0d got addr %h @%0d exp addr %h @%0d", it, k, grq[k].addr, grq[k].rel, exp_addr(ba, bb, k), exp_g[k]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; spur = 1'b0;
    base_a = 32'd0; base_b = 32'd0; rd_in = 5'd0;
    clear_contend();
    test_reset();
    test_basic();
    test_signed();
    test_contention();
    test_reset_mid();
    test_saturation();
    test_back_to_back();
    test_random();
    n_cmp++; if (stray_wb !== 0) begin n_err++; $display("FAIL stray_wb_en got %0d exp 0", stray_wb); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
